// File: rtl/pipe_ctl.sv
// -----------------------------------------------------------------------------
// pipe_ctl -- global pipeline sequencer for the five-stage MIPS core.
//
// Owns post-reset pipeline clearing, the instruction-fill window, debug
// halt/single-step and the run-time hazard stall/flush decode for the fetch,
// decode, execute and memory stages.
//
// Parameters
//   BOOT_FLUSH_CYCLES  cycles of full flush after reset release (1..255)
//   CNT_W              width of the advance counter
//
// Ports
//   clk               in   core clock
//   reset             in   asynchronous, active-low reset
//   FillVal_FL0       in   external instruction-fill write active this cycle
//   Start             in   level, permits leaving WAIT
//   BranchTaken_EXM1  in   taken branch/redirect resolved in EX
//   LwStall_EXM1      in   load-use hazard detected in EX
//   MemBusy_ME        in   memory stage needs another cycle (global freeze)
//   HaltReq           in   level, debug halt request
//   StepReq           in   pulse, advance one cycle while halted
//   Stall_FE/DE/EX/ME out  stage hold
//   flush_FE/DE/EX/ME out  stage clear
//   Running           out  state is RUN or STEP
//   Halted            out  state is HALT
//   AdvanceCnt        out  count of cycles in which the pipeline advanced
// -----------------------------------------------------------------------------
module pipe_ctl #(
    parameter int BOOT_FLUSH_CYCLES = 5,
    parameter int CNT_W             = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             FillVal_FL0,
    input  logic             Start,
    input  logic             BranchTaken_EXM1,
    input  logic             LwStall_EXM1,
    input  logic             MemBusy_ME,
    input  logic             HaltReq,
    input  logic             StepReq,
    output logic             Stall_FE,
    output logic             Stall_DE,
    output logic             Stall_EX,
    output logic             Stall_ME,
    output logic             flush_FE,
    output logic             flush_DE,
    output logic             flush_EX,
    output logic             flush_ME,
    output logic             Running,
    output logic             Halted,
    output logic [CNT_W-1:0] AdvanceCnt
);

    typedef enum logic [2:0] {
        ST_BOOT = 3'd0,
        ST_WAIT = 3'd1,
        ST_RUN  = 3'd2,
        ST_HALT = 3'd3,
        ST_STEP = 3'd4
    } state_t;

    // Boot counter reload value: counts BOOT_FLUSH_CYCLES-1 down to 0, so the
    // machine spends exactly BOOT_FLUSH_CYCLES cycles in BOOT.
    localparam logic [7:0] BOOT_INIT = 8'(BOOT_FLUSH_CYCLES - 1);

    // Control vector layout: {Stall_FE, Stall_DE, Stall_EX, Stall_ME,
    //                         flush_FE, flush_DE, flush_EX, flush_ME}
    localparam logic [7:0] CTL_BOOT = 8'b0000_1111;
    localparam logic [7:0] CTL_WAIT = 8'b1000_0100;
    localparam logic [7:0] CTL_HALT = 8'b1111_0000;

    state_t           state_r;
    logic [7:0]       bootCnt_r;
    logic [CNT_W-1:0] advanceCnt_r;
    logic [7:0]       ctl_s;
    logic             advancing_s;

    // Run-time hazard decode. A memory freeze suppresses bubble insertion so
    // the branch/load-use hazard is re-evaluated once memory releases.
    function automatic logic [7:0] hazardDecode(
        input logic branchTaken,
        input logic lwStall,
        input logic memBusy
    );
        logic frontStall;
        frontStall = memBusy | lwStall;
        return {frontStall, frontStall, memBusy, memBusy,
                1'b0, branchTaken & ~memBusy, lwStall & ~memBusy, 1'b0};
    endfunction

    // Sequencer state machine and boot countdown.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_BOOT;
            bootCnt_r <= BOOT_INIT;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    if (bootCnt_r == 8'd0) begin
                        state_r <= ST_WAIT;
                    end else begin
                        bootCnt_r <= bootCnt_r - 8'd1;
                    end
                end
                ST_WAIT: begin
                    if (Start && !FillVal_FL0) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (FillVal_FL0) begin
                        state_r <= ST_WAIT;
                    end else if (HaltReq) begin
                        state_r <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (FillVal_FL0) begin
                        state_r <= ST_WAIT;
                    end else if (StepReq) begin
                        state_r <= ST_STEP;
                    end else if (!HaltReq) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_STEP: begin
                    // A step always completes; only a fill can cut it short.
                    if (FillVal_FL0) begin
                        state_r <= ST_WAIT;
                    end else if (!MemBusy_ME) begin
                        state_r <= ST_HALT;
                    end
                end
                default: begin
                    state_r   <= ST_BOOT;
                    bootCnt_r <= BOOT_INIT;
                end
            endcase
        end
    end

    assign advancing_s = ((state_r == ST_RUN) || (state_r == ST_STEP)) && !MemBusy_ME;

    // Count cycles in which the pipeline actually moved forward.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            advanceCnt_r <= {CNT_W{1'b0}};
        end else if (advancing_s) begin
            advanceCnt_r <= advanceCnt_r + CNT_W'(1);
        end else begin
            advanceCnt_r <= advanceCnt_r;
        end
    end

    // Stall/flush decode: combinational so hazards act in the same cycle.
    // State is reset asynchronously, so the BOOT pattern appears as soon as
    // reset asserts.
    always_comb begin
        ctl_s = CTL_BOOT;
        case (state_r)
            ST_BOOT: ctl_s = CTL_BOOT;
            ST_WAIT: ctl_s = CTL_WAIT;
            ST_RUN:  ctl_s = hazardDecode(BranchTaken_EXM1, LwStall_EXM1, MemBusy_ME);
            ST_HALT: ctl_s = CTL_HALT;
            ST_STEP: ctl_s = hazardDecode(BranchTaken_EXM1, LwStall_EXM1, MemBusy_ME);
            default: ctl_s = CTL_BOOT;
        endcase
    end

    assign {Stall_FE, Stall_DE, Stall_EX, Stall_ME,
            flush_FE, flush_DE, flush_EX, flush_ME} = ctl_s;

    assign Running    = (state_r == ST_RUN) || (state_r == ST_STEP);
    assign Halted     = (state_r == ST_HALT);
    assign AdvanceCnt = advanceCnt_r;

endmodule

// File: tb/tb_pipe_ctl.sv
module tb_pipe_ctl;

    localparam int NBOOT  = 5;
    localparam int M_BOOT = 0;
    localparam int M_WAIT = 1;
    localparam int M_RUN  = 2;
    localparam int M_HALT = 3;
    localparam int M_STEP = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, fillVal, start, branch, lwStall, memBusy, haltReq, stepReq;
    logic sFe, sDe, sEx, sMe, fFe, fDe, fEx, fMe, running, halted;
    logic [31:0] advCnt;
    logic [9:0]  o2;
    logic [3:0]  advCnt4;

    pipe_ctl #(.BOOT_FLUSH_CYCLES(NBOOT), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .FillVal_FL0(fillVal), .Start(start),
        .BranchTaken_EXM1(branch), .LwStall_EXM1(lwStall), .MemBusy_ME(memBusy),
        .HaltReq(haltReq), .StepReq(stepReq),
        .Stall_FE(sFe), .Stall_DE(sDe), .Stall_EX(sEx), .Stall_ME(sMe),
        .flush_FE(fFe), .flush_DE(fDe), .flush_EX(fEx), .flush_ME(fMe),
        .Running(running), .Halted(halted), .AdvanceCnt(advCnt)
    );

    pipe_ctl #(.BOOT_FLUSH_CYCLES(NBOOT), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .FillVal_FL0(fillVal), .Start(start),
        .BranchTaken_EXM1(branch), .LwStall_EXM1(lwStall), .MemBusy_ME(memBusy),
        .HaltReq(haltReq), .StepReq(stepReq),
        .Stall_FE(o2[9]), .Stall_DE(o2[8]), .Stall_EX(o2[7]), .Stall_ME(o2[6]),
        .flush_FE(o2[5]), .flush_DE(o2[4]), .flush_EX(o2[3]), .flush_ME(o2[2]),
        .Running(o2[1]), .Halted(o2[0]), .AdvanceCnt(advCnt4)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: abstract sequencer state, boot countdown, advance count.
    int          mState;
    int          mBoot;
    int unsigned mCnt;

    wire [55:0] obsAll = {sFe, sDe, sEx, sMe, fFe, fDe, fEx, fMe, running, halted,
                          o2, advCnt, advCnt4};

    // Expected {Stall x4, flush x4, Running, Halted} from the model state.
    function automatic logic [9:0] expOuts();
        logic fs;
        if (!reset) return 10'b0000_1111_00;
        case (mState)
            M_BOOT: return 10'b0000_1111_00;
            M_WAIT: return 10'b1000_0100_00;
            M_HALT: return 10'b1111_0000_01;
            M_RUN, M_STEP: begin
                fs = memBusy | lwStall;
                return {fs, fs, memBusy, memBusy, 1'b0, branch & ~memBusy,
                        lwStall & ~memBusy, 1'b0, 1'b1, 1'b0};
            end
            default: return 10'h3FF;
        endcase
    endfunction

    function automatic logic [55:0] expAll();
        logic [3:0] m4;
        m4 = mCnt[3:0];
        return {expOuts(), expOuts(), mCnt, m4};
    endfunction

    task automatic setIn(input logic f, input logic s, input logic b, input logic l,
                         input logic m, input logic h, input logic st);
        fillVal = f; start = s; branch = b; lwStall = l;
        memBusy = m; haltReq = h; stepReq = st;
    endtask

    // Advance one clock: model computes its next state from current inputs.
    task automatic tick();
        int ns, nb;
        int unsigned nc;
        ns = mState; nb = mBoot; nc = mCnt;
        if (!reset) begin
            ns = M_BOOT; nb = NBOOT - 1; nc = 0;
        end else begin
            if ((mState == M_RUN || mState == M_STEP) && !memBusy) nc = mCnt + 1;
            case (mState)
                M_BOOT: if (mBoot == 0) ns = M_WAIT; else nb = mBoot - 1;
                M_WAIT: if (start && !fillVal) ns = M_RUN;
                M_RUN:  if (fillVal) ns = M_WAIT; else if (haltReq) ns = M_HALT;
                M_HALT: if (fillVal) ns = M_WAIT; else if (stepReq) ns = M_STEP;
                        else if (!haltReq) ns = M_RUN;
                M_STEP: if (fillVal) ns = M_WAIT; else if (!memBusy) ns = M_HALT;
                default: ns = M_BOOT;
            endcase
        end
        @(posedge clk);
        #1;
        mState = ns; mBoot = nb; mCnt = nc;
    endtask

    task automatic test_reset();
        int bootSeen;
        setIn(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        mState = M_BOOT; mBoot = NBOOT - 1; mCnt = 0;
        #2;
        checks++;
        if (obsAll !== expAll()) begin
            errors++; $display("FAIL reset_hold obs=%h exp=%h", obsAll, expAll());
        end
        tick(); tick();
        reset = 1'b1;
        bootSeen = 0;
        for (int i = 0; i < 20; i++) begin
            #3;
            checks++;
            if (obsAll !== expAll()) begin
                errors++; $display("FAIL boot_cycle obs=%h exp=%h", obsAll, expAll());
            end
            if (!fFe) break;
            bootSeen++;
            tick();
        end
        checks++;
        if (bootSeen != NBOOT) begin
            errors++; $display("FAIL boot_length got=%0d want=%0d", bootSeen, NBOOT);
        end
        checks++;
        if ({sFe, fDe, running} !== 3'b110) begin
            errors++; $display("FAIL wait_outputs got=%b want=110", {sFe, fDe, running});
        end
        tick();
    endtask

    task automatic test_wait_start();
        setIn(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #3;
            checks++;
            if (obsAll !== expAll()) begin
                errors++; $display("FAIL wait_fill obs=%h exp=%h", obsAll, expAll());
            end
            tick();
        end
        checks++;
        if (running !== 1'b0) begin
            errors++; $display("FAIL wait_hold got=%b want=0", running);
        end
        fillVal = 1'b0;
        #3;
        tick();
        checks++;
        if (running !== 1'b1 || advCnt !== 32'd0) begin
            errors++; $display("FAIL start_run running=%b cnt=%0d want 1/0", running, advCnt);
        end
        start = 1'b0;
        tick();
        checks++;
        if (advCnt !== 32'd1) begin
            errors++; $display("FAIL first_advance got=%0d want=1", advCnt);
        end
    endtask

    task automatic test_hazards();
        logic [2:0] hzIn  [4] = '{3'b010, 3'b011, 3'b100, 3'b110}; // {branch,lw,busy}
        logic [7:0] hzExp [4] = '{8'b1100_0010, 8'b1111_0000, 8'b0000_0100, 8'b1100_0110};
        for (int i = 0; i < 4; i++) begin
            setIn(0, 0, hzIn[i][2], hzIn[i][1], hzIn[i][0], 0, 0);
            #3;
            checks++;
            if ({sFe, sDe, sEx, sMe, fFe, fDe, fEx, fMe} !== hzExp[i]) begin
                errors++; $display("FAIL hazard_%0d got=%b want=%b", i,
                                   {sFe, sDe, sEx, sMe, fFe, fDe, fEx, fMe}, hzExp[i]);
            end
            tick();
            setIn(0, 0, 0, 0, 0, 0, 0);
            #3;
            checks++;
            if (obsAll !== expAll()) begin
                errors++; $display("FAIL hazard_clear obs=%h exp=%h", obsAll, expAll());
            end
            tick();
        end
    endtask

    task automatic test_halt_step();
        int unsigned c0;
        int stepCyc;
        setIn(0, 0, 0, 0, 0, 1, 0);
        #3;
        tick();
        checks++;
        if (halted !== 1'b1 || {sFe, sDe, sEx, sMe} !== 4'b1111) begin
            errors++; $display("FAIL halt_enter halted=%b stalls=%b", halted, {sFe, sDe, sEx, sMe});
        end
        c0 = mCnt;
        for (int k = 0; k < 3; k++) begin
            stepReq = 1'b1;
            #3;
            tick();
            stepReq = 1'b0;
            for (int j = 0; j < 3; j++) begin
                #3;
                checks++;
                if (obsAll !== expAll()) begin
                    errors++; $display("FAIL step_seq obs=%h exp=%h", obsAll, expAll());
                end
                tick();
            end
        end
        checks++;
        if (advCnt !== c0 + 32'd3) begin
            errors++; $display("FAIL step_count got=%0d want=%0d", advCnt, c0 + 3);
        end
        stepReq = 1'b1;
        #3;
        tick();
        stepReq = 1'b0;
        stepCyc = 0;
        for (int j = 0; j < 10; j++) begin
            memBusy = (j < 2);
            #3;
            checks++;
            if (obsAll !== expAll()) begin
                errors++; $display("FAIL step_busy obs=%h exp=%h", obsAll, expAll());
            end
            if (!running) break;
            stepCyc++;
            tick();
        end
        memBusy = 1'b0;
        checks++;
        if (stepCyc != 3 || advCnt !== c0 + 32'd4) begin
            errors++; $display("FAIL step_busy_len cyc=%0d cnt=%0d want 3/%0d", stepCyc, advCnt, c0 + 4);
        end
        haltReq = 1'b0;
        tick();
        checks++;
        if (running !== 1'b1 || halted !== 1'b0) begin
            errors++; $display("FAIL halt_release running=%b halted=%b", running, halted);
        end
    endtask

    task automatic test_fill();
        setIn(1, 0, 0, 0, 0, 0, 0);
        #3;
        tick();
        checks++;
        if ({sFe, fDe, running, halted} !== 4'b1100) begin
            errors++; $display("FAIL fill_from_run got=%b want=1100", {sFe, fDe, running, halted});
        end
        setIn(0, 1, 0, 0, 0, 0, 0);
        #3; tick();
        haltReq = 1'b1;
        #3; tick();
        fillVal = 1'b1;
        #3;
        checks++;
        if (obsAll !== expAll()) begin
            errors++; $display("FAIL fill_in_halt obs=%h exp=%h", obsAll, expAll());
        end
        tick();
        checks++;
        if ({sFe, fDe, running, halted} !== 4'b1100) begin
            errors++; $display("FAIL fill_from_halt got=%b want=1100", {sFe, fDe, running, halted});
        end
        setIn(0, 1, 0, 0, 0, 0, 0);
        #3; tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            fillVal = ($urandom_range(0, 19) == 0);
            start   = $urandom_range(0, 1);
            branch  = ($urandom_range(0, 2) == 0);
            lwStall = ($urandom_range(0, 2) == 0);
            memBusy = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) haltReq = ~haltReq;
            stepReq = ($urandom_range(0, 2) == 0);
            #3;
            checks++;
            if (obsAll !== expAll()) begin
                errors++; $display("FAIL random_%0d obs=%h exp=%h", i, obsAll, expAll());
            end
            tick();
        end
        setIn(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #3; tick();
        end
    endtask

    task automatic test_reset_wrap();
        #1;
        reset = 1'b0;
        #1;
        mState = M_BOOT; mBoot = NBOOT - 1; mCnt = 0;
        checks++;
        if ({fFe, fDe, fEx, fMe, sFe, sDe, sEx, sMe, running, halted} !== 10'b1111_0000_00
            || advCnt !== 32'd0 || advCnt4 !== 4'd0) begin
            errors++; $display("FAIL reset_mid outs=%b cnt=%0d", {fFe, fDe, fEx, fMe, sFe, sDe,
                               sEx, sMe, running, halted}, advCnt);
        end
        tick(); tick();
        reset = 1'b1;
        setIn(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20 && mState != M_RUN; i++) begin
            #3;
            checks++;
            if (obsAll !== expAll()) begin
                errors++; $display("FAIL reboot obs=%h exp=%h", obsAll, expAll());
            end
            tick();
        end
        for (int i = 0; i < 17; i++) begin
            branch  = $urandom_range(0, 1);
            lwStall = $urandom_range(0, 1);
            #3; tick();
        end
        checks++;
        if (advCnt4 !== 4'd1 || advCnt !== 32'd17) begin
            errors++; $display("FAIL cnt_wrap w4=%0d w32=%0d want 1/17", advCnt4, advCnt);
        end
    endtask

    initial begin
        test_reset();
        test_wait_start();
        test_hazards();
        test_halt_step();
        test_fill();
        test_random();
        test_reset_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
